keypad_display_drv: RTL and testbench

- Consumer end of the keypad scanner interface. Takes the scanner's held key code (`digito`) and its rolling position index (`desp`), and detects each new key event from a change in `desp`.
- Stores valid hex digits in a per-position digit buffer.
- Drives a time-multiplexed common-anode 7-segment display showing the entered digits.
- Sits between the keypad scanner and the board display pins, on the same slow scan clock.

---
 rtl/keypad_display_drv_pkg.sv | 18 +
 rtl/keypad_display_drv_seg7_hex_dec.sv | 11 +
 rtl/keypad_display_drv.sv | 91 +++++++++
 tb/tb_keypad_display_drv.sv | 138 +++++++++++++
 4 files changed

// File: rtl/keypad_display_drv_pkg.sv
// Shared constants for the keypad display path: key codes, blank pattern and hex segment table.
package keypad_display_drv_pkg;

  typedef logic [3:0] hex_t;

  localparam logic [4:0] KEY_NONE  = 5'd16;
  localparam logic [4:0] KEY_INV   = 5'd17;
  localparam hex_t       KEY_CLR   = 4'hF;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/keypad_display_drv_seg7_hex_dec.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
module seg7_hex_dec
  import keypad_display_drv_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  assign seg_n = ~SEG_PAT[hex];

endmodule

// File: rtl/keypad_display_drv.sv
// Keypad-to-display driver: latches scanner key events into a digit buffer and multiplexes it
// onto a common-anode 7-segment display. Define KEYPAD_CLEAR_KEY_EN to make key F clear the display.
module keypad_display_drv
  import keypad_display_drv_pkg::*;
#(
  parameter int N_DIG    = 3,
  parameter int SCAN_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       digito,
  input  logic [1:0]       desp,
  output logic [N_DIG-1:0] an_n,
  output logic [6:0]       seg_n,
  output logic             full
);

  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [1:0]       desp_q;
  logic [3:0]       dbuf [N_DIG];
  logic [N_DIG-1:0] valid;
  logic [IDX_W-1:0] idx;
  logic [PRE_W-1:0] presc;

  logic key_evt, key_hex, in_range, clr_en, wr_en;
  logic presc_wrap, idx_last;
  logic [6:0] seg_dec;

  assign key_evt  = (desp != desp_q);
  assign key_hex  = (digito < KEY_NONE);
  assign in_range = (32'(desp) < 32'(N_DIG));

`ifdef KEYPAD_CLEAR_KEY_EN
  assign clr_en = key_evt && key_hex && (digito[3:0] == KEY_CLR);
`else
  assign clr_en = 1'b0;
`endif

  assign wr_en = key_evt && key_hex && in_range && !clr_en;

  // Stage 1: event detect and buffer write
  always_ff @(posedge clk) begin
    if (rst) begin
      desp_q <= '0;
      valid  <= '0;
      for (int i = 0; i < N_DIG; i++) dbuf[i] <= '0;
    end else begin
      desp_q <= desp;
      if (clr_en) begin
        valid <= '0;
      end else if (wr_en) begin
        dbuf[desp]  <= digito[3:0];
        valid[desp] <= 1'b1;
      end
    end
  end

  assign presc_wrap = (presc == PRE_W'(SCAN_DIV - 1));
  assign idx_last   = (idx == IDX_W'(N_DIG - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc_wrap ? '0 : presc + 1'b1;
      if (presc_wrap) idx <= idx_last ? '0 : idx + 1'b1;
    end
  end

  seg7_hex_dec u_dec (
    .hex   (dbuf[idx]),
    .seg_n (seg_dec)
  );

  // Stage 2: registered display outputs and full flag
  always_ff @(posedge clk) begin
    if (rst) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
      full  <= 1'b0;
    end else begin
      an_n  <= ~(N_DIG'(1) << idx);
      seg_n <= valid[idx] ? seg_dec : SEG_BLANK;
      full  <= &valid;
    end
  end

endmodule

// File: tb/tb_keypad_display_drv.sv
// Directed self-checking bench for keypad_display_drv (N_DIG=3, SCAN_DIV=1).
module tb_keypad_display_drv;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] digito = 5'd16;
  logic [1:0] desp = 2'd0;
  logic [2:0] an_n;
  logic [6:0] seg_n;
  logic       full;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [6:0] exp_seg [3];
  logic       exp_full;
  logic [2:0] an_pat [3];

  keypad_display_drv #(.N_DIG(3), .SCAN_DIV(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .digito (digito),
    .desp   (desp),
    .an_n   (an_n),
    .seg_n  (seg_n),
    .full   (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic blank_all();
    for (int i = 0; i < 3; i++) exp_seg[i] = 7'h7F;
    exp_full = 1'b0;
  endtask

  // One clock; outputs sampled 1 time unit after the edge against the scan position.
  task automatic step();
    int slot;
    @(posedge clk);
    #1;
    cyc++;
    slot = (cyc - 1) % 3;
    chk($sformatf("an_n[c%0d]", cyc), 32'(an_n), 32'(an_pat[slot]));
    chk($sformatf("seg_n[c%0d,s%0d]", cyc, slot), 32'(seg_n), 32'(exp_seg[slot]));
    chk($sformatf("full[c%0d]", cyc), 32'(full), 32'(exp_full));
  endtask

  task automatic key(input logic [1:0] d, input logic [4:0] c);
    desp   = d;
    digito = c;
    step();
  endtask

  initial begin
    an_pat[0] = 3'b110;
    an_pat[1] = 3'b101;
    an_pat[2] = 3'b011;
    blank_all();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an_n", 32'(an_n), 32'h7);
    chk("rst_seg_n", 32'(seg_n), 32'h7F);
    chk("rst_full", 32'(full), 32'h0);
    rst = 1'b0;
    cyc = 0;

    // idle scan
    repeat (10) step();

    // single key into slot 1
    key(2'd1, 5'd5);
    exp_seg[1] = 7'h12;
    repeat (3) step();

    // no-key, invalid-column and out-of-range events are ignored
    key(2'd2, 5'd16);
    key(2'd3, 5'd17);
    key(2'd0, 5'd16);
    key(2'd3, 5'd4);
    repeat (3) step();

    // overwrite slot 1, fill slots 2 and 0
    key(2'd1, 5'd7);
    exp_seg[1] = 7'h78;
    key(2'd2, 5'd8);
    exp_seg[2] = 7'h00;
    key(2'd0, 5'd10);
    exp_seg[0] = 7'h08;
    exp_full   = 1'b1;
    repeat (4) step();

    // key F
    key(2'd1, 5'd15);
`ifdef KEYPAD_CLEAR_KEY_EN
    blank_all();
`else
    exp_seg[1] = 7'h0E;
`endif
    repeat (3) step();

    // refill all slots
    key(2'd2, 5'd1);
    exp_seg[2] = 7'h79;
    key(2'd1, 5'd2);
    exp_seg[1] = 7'h24;
    key(2'd0, 5'd3);
    exp_seg[0] = 7'h30;
    exp_full   = 1'b1;
    repeat (4) step();

    // reset mid-scan while full
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_an_n", 32'(an_n), 32'h7);
    chk("mid_rst_seg_n", 32'(seg_n), 32'h7F);
    chk("mid_rst_full", 32'(full), 32'h0);
    rst = 1'b0;
    cyc = 0;
    blank_all();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
